wait_state_ram: RTL

- Parametrised successor of the SoC word RAM. Adds byte-masked writes, configurable read/write latency with busy handshakes, and a configurable depth.
- Sits between the multicycle RISC-V processor and storage. The processor holds its LOAD/STORE state while rbusy/wbusy is high.
- Optionally decodes a memory-mapped IO page for LEDs and a cycle counter.

---
 rtl/wait_state_ram.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/wait_state_ram.sv
// wait_state_ram: word RAM with byte-masked writes, a configurable access latency and busy
// handshakes, plus an optional memory-mapped IO page.
//
// Optional feature macro: MEM_IO_EN. When defined, mem_addr[IO_BIT]=1 selects an IO page
// holding an LED register (offset 0) and a free-running cycle counter (offset 1). IO
// accesses never wait. When undefined, IO_BIT is an ordinary ignored address bit and leds
// is tied to 0.
//
// Ports:
//   clk        clock
//   resetn     synchronous active-low reset
//   mem_addr   byte address, word index = mem_addr[AW+1:2]
//   mem_rstrb  read request strobe
//   mem_wdata  write data
//   mem_wmask  byte write enables (bit i -> bits 8i+7:8i)
//   mem_rdata  registered read data, holds until the next read completes
//   mem_rbusy  read in progress
//   mem_wbusy  write in progress
//   leds       LED register
module wait_state_ram #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned IO_BIT      = 22,
  parameter int unsigned LED_WIDTH   = 5
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [31:0]          mem_addr,
  input  logic                 mem_rstrb,
  input  logic [31:0]          mem_wdata,
  input  logic [3:0]           mem_wmask,
  output logic [31:0]          mem_rdata,
  output logic                 mem_rbusy,
  output logic                 mem_wbusy,
  output logic [LED_WIDTH-1:0] leds
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  // Zero wait states: access happens straight out of IDLE, like the legacy RAM.
  localparam bit Direct = (WAIT_STATES == 0);
  localparam logic [3:0] CntLoad = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {StIdle, StWait, StAccess} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      wmask_q, wmask_d;
  logic            rd_q, rd_d;
  logic [31:0]     rdata_q;

  logic [31:0]     ram [DEPTH_WORDS];

  logic            io_sel;
  logic            io_rd;
  logic [31:0]     io_rdata;
  logic            req;
  logic            ram_req;

  logic            acc_en;
  logic [AW-1:0]   acc_idx;
  logic [31:0]     acc_wdata;
  logic [3:0]      acc_wmask;
  logic            acc_rd;
  logic            ram_we;

  logic            unused_addr;
  assign unused_addr = ^{mem_addr[31:AW+2], mem_addr[1:0]};

  assign req     = (state_q == StIdle) && (mem_rstrb || (mem_wmask != 4'd0));
  assign ram_req = req && !io_sel;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    rd_d    = rd_q;
    unique case (state_q)
      StIdle: begin
        if (ram_req && !Direct) begin
          idx_d   = mem_addr[AW+1:2];
          wdata_d = mem_wdata;
          wmask_d = mem_wmask;
          rd_d    = mem_rstrb;
          cnt_d   = CntLoad;
          // A single wait state leaves no room for WAIT: the access cycle is t+1.
          state_d = (WAIT_STATES == 1) ? StAccess : StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = StAccess;
      end
      StAccess: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      wmask_q <= 4'd0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      rd_q    <= rd_d;
    end
  end

  assign mem_rbusy = (state_q != StIdle) && rd_q;
  assign mem_wbusy = (state_q != StIdle) && (wmask_q != 4'd0);

  always_comb begin
    acc_en    = 1'b0;
    acc_idx   = idx_q;
    acc_wdata = wdata_q;
    acc_wmask = wmask_q;
    acc_rd    = rd_q;
    if (Direct) begin
      acc_en    = ram_req;
      acc_idx   = mem_addr[AW+1:2];
      acc_wdata = mem_wdata;
      acc_wmask = mem_wmask;
      acc_rd    = mem_rstrb;
    end else begin
      acc_en = (state_q == StAccess);
    end
  end

  // Reset gates the commit so a write in flight is dropped.
  assign ram_we = resetn && acc_en && (acc_wmask != 4'd0);

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_wmask[i]) ram[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

  // Nonblocking read of the same word being written returns the pre-write value.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rdata_q <= 32'd0;
    end else if (acc_en && acc_rd) begin
      rdata_q <= ram[acc_idx];
    end else if (io_rd) begin
      rdata_q <= io_rdata;
    end
  end

  assign mem_rdata = rdata_q;

`ifdef MEM_IO_EN
  logic [LED_WIDTH-1:0] leds_q;
  logic [31:0]          cycle_q;
  logic                 io_req;

  assign io_sel = mem_addr[IO_BIT];
  assign io_req = req && io_sel;
  assign io_rd  = io_req && mem_rstrb;

  always_comb begin
    io_rdata = 32'd0;
    case (mem_addr[3:2])
      2'd0:    io_rdata = 32'(leds_q);
      2'd1:    io_rdata = cycle_q;
      default: io_rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      leds_q  <= '0;
      cycle_q <= 32'd0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (io_req && (mem_addr[3:2] == 2'd0) && mem_wmask[0]) begin
        leds_q <= mem_wdata[LED_WIDTH-1:0];
      end
    end
  end

  assign leds = leds_q;
`else
  assign io_sel   = 1'b0;
  assign io_rd    = 1'b0;
  assign io_rdata = 32'd0;
  assign leds     = '0;
`endif

endmodule
